// File: rtl/dice_pkg.sv
// Shared types and constants for the electronic dice controller.
// Also holds the face-advance helper used by the control FSM.
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROLL = 2'd1,
        SLOW = 2'd2,
        SHOW = 2'd3
    } dice_state_e;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned FACE_W = 3;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned K_W    = 3;

    localparam logic [FACE_W-1:0] FACE_MIN = 3'd1;
    localparam logic [FACE_W-1:0] FACE_MAX = 3'd6;

    function automatic logic [FACE_W-1:0] next_face(
        input logic [FACE_W-1:0] f
    );
        return (f >= FACE_MAX) ? FACE_MIN : f + 1'b1;
    endfunction

endpackage

// File: rtl/dice_if.sv
// Button in, display digit and status out between the dice
// controller and its surroundings.
interface dice_if;
    import dice_pkg::*;

    logic              btn;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;

    modport master (
        output btn,
        input  data,
        input  busy,
        input  done
    );

    modport slave (
        input  btn,
        output data,
        output busy,
        output done
    );

endinterface

// File: rtl/dice_step_timer.sv
// Face-step divider: ticks once every ROLL_DIV<<k cycles,
// restarting from zero on clear or on its own tick.
module dice_step_timer
    import dice_pkg::*;
#(
    parameter int unsigned ROLL_DIV = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic [K_W-1:0] k,
    output logic           tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] limit;

    assign limit = DIV_W'(ROLL_DIV) << k;
    assign tick  = ~clear & (cnt_q == limit - 1'b1);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dice_ctrl.sv
// Dice controller: rolls while the button is held, then slows
// down over a few doubling steps and shows the final face.
module dice_ctrl
    import dice_pkg::*;
#(
    parameter int unsigned ROLL_DIV   = 4,
    parameter int unsigned SLOW_STEPS = 4
) (
    input  logic    clk,
    input  logic    rst,
    dice_if.slave   bus
);

    dice_state_e       state_q, state_d;
    logic [FACE_W-1:0] face_q,  face_d;
    logic [K_W-1:0]    k_q,     k_d;
    logic              btn_q,   btn_d;
    logic              armed_q, armed_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic rise;
    logic clear;
    logic tick;

    dice_step_timer #(
        .ROLL_DIV (ROLL_DIV)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .k     (k_q),
        .tick  (tick)
    );

    // armed_q stays low after reset until btn is seen low,
    // so a button held through reset never counts as a press
    assign rise = bus.btn & ~btn_q & armed_q;

    always_comb begin
        state_d = state_q;
        face_d  = face_q;
        k_d     = k_q;
        btn_d   = bus.btn;
        armed_d = armed_q | ~bus.btn;
        clear   = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                clear = 1'b1;
                if (rise) begin
                    state_d = ROLL;
                    k_d     = '0;
                end
            end
            ROLL: begin
                k_d = '0;
                if (!bus.btn) begin
                    state_d = SLOW;
                    clear   = 1'b1;
                end else if (tick) begin
                    face_d = next_face(face_q);
                end
            end
            SLOW: begin
                // a new press wins over a step expiring together
                if (rise) begin
                    state_d = ROLL;
                    k_d     = '0;
                    clear   = 1'b1;
                end else if (tick) begin
                    face_d = next_face(face_q);
                    if (k_q == K_W'(SLOW_STEPS - 1)) begin
                        state_d = SHOW;
                        done_d  = 1'b1;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            SHOW: begin
                clear = 1'b1;
                if (rise) begin
                    state_d = ROLL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        data_d = (state_d == IDLE) ? '0 : DATA_W'(face_d);
        busy_d = (state_d == ROLL) || (state_d == SLOW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            face_q  <= FACE_MIN;
            k_q     <= '0;
            btn_q   <= 1'b0;
            armed_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            face_q  <= face_d;
            k_q     <= k_d;
            btn_q   <= btn_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.data = data_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_dice_ctrl.sv
// Scoreboard bench for dice_ctrl with ROLL_DIV=2, SLOW_STEPS=3:
// directed scenarios followed by random button/reset activity.
module tb_dice_ctrl;
    import dice_pkg::*;

    localparam int RD = 2;
    localparam int SS = 3;

    localparam int M_IDLE = 0;
    localparam int M_ROLL = 1;
    localparam int M_SLOW = 2;
    localparam int M_SHOW = 3;

    typedef struct packed {
        logic [3:0] data;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    dice_if ifc ();

    dice_ctrl #(
        .ROLL_DIV   (RD),
        .SLOW_STEPS (SS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    // reference model: mode, face, cycles left in the current step,
    // number of slow-down steps already taken
    int m_mode  = M_IDLE;
    int m_face  = 1;
    int m_left  = 0;
    int m_step  = 0;
    bit m_prev  = 1'b0;
    bit m_armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input bit b, input bit r);
        exp_t e;
        bit   rise;
        bit   dn;
        dn = 1'b0;
        if (r) begin
            m_mode  = M_IDLE;
            m_face  = 1;
            m_left  = 0;
            m_step  = 0;
            m_prev  = 1'b0;
            m_armed = 1'b0;
        end else begin
            rise = b && !m_prev && m_armed;
            case (m_mode)
                M_IDLE, M_SHOW: begin
                    if (rise) begin
                        m_mode = M_ROLL;
                        m_left = RD;
                    end
                end
                M_ROLL: begin
                    if (!b) begin
                        m_mode = M_SLOW;
                        m_step = 0;
                        m_left = RD;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_face = (m_face % 6) + 1;
                            m_left = RD;
                        end
                    end
                end
                default: begin
                    if (rise) begin
                        m_mode = M_ROLL;
                        m_left = RD;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_face = (m_face % 6) + 1;
                            m_step++;
                            if (m_step == SS) begin
                                m_mode = M_SHOW;
                                dn = 1'b1;
                            end else begin
                                m_left = RD * (2 ** m_step);
                            end
                        end
                    end
                end
            endcase
            m_prev  = b;
            m_armed = m_armed || !b;
        end
        e.data = (m_mode == M_IDLE) ? 4'd0 : 4'(m_face);
        e.busy = (m_mode == M_ROLL) || (m_mode == M_SLOW);
        e.done = dn;
        sb.push_back(e);
    endtask

    task automatic cyc(input bit b, input bit r);
        ifc.btn = b;
        rst = r;
        @(posedge clk);
        model_step(b, r);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_data", ifc.data, e.data);
            check("sb_busy", ifc.busy, e.busy);
            check("sb_done", ifc.done, e.done);
        end
    end

    int roll_tbl[14] = '{1,1,2,2,3,3,4,4,5,5,6,6,1,1};
    int slow_dat[16] = '{3,3,4,4,4,4,5,5,5,5,5,5,5,5,6,6};

    initial begin
        int n;
        int lvl;
        int len;
        bit rr;
        ifc.btn = 1'b0;

        // reset
        cyc(0, 1);
        check("rst_data", ifc.data, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_done", ifc.done, 0);
        cyc(0, 0);
        cyc(0, 0);

        // roll with wrap
        for (int i = 0; i < 14; i++) begin
            cyc(1, 0);
            check("roll_data", ifc.data, roll_tbl[i]);
            check("roll_busy", ifc.busy, 1);
        end

        // slow-down from face 3
        n = 0;
        while (ifc.data != 4'd3 && n < 20) begin
            cyc(1, 0);
            n++;
        end
        check("reach_face3", ifc.data, 3);
        for (int j = 0; j < 16; j++) begin
            cyc(0, 0);
            check("slow_data", ifc.data, slow_dat[j]);
            check("slow_busy", ifc.busy, (j <= 13) ? 1 : 0);
            check("slow_done", ifc.done, (j == 14) ? 1 : 0);
        end
        repeat (5) cyc(0, 0);

        // re-press during slow step k=1
        repeat (3) cyc(1, 0);
        repeat (4) cyc(0, 0);
        cyc(1, 0);
        check("repress_busy", ifc.busy, 1);
        check("repress_done", ifc.done, 0);
        repeat (6) cyc(1, 0);
        repeat (20) cyc(0, 0);

        // reset during roll at face 5
        cyc(1, 0);
        n = 0;
        while (ifc.data != 4'd5 && n < 20) begin
            cyc(1, 0);
            n++;
        end
        check("reach_face5", ifc.data, 5);
        cyc(1, 1);
        check("rrst_data", ifc.data, 0);
        check("rrst_busy", ifc.busy, 0);
        cyc(0, 0);
        cyc(1, 0);
        check("rrst_first", ifc.data, 1);
        check("rrst_busy1", ifc.busy, 1);
        repeat (4) cyc(0, 0);

        // button held through reset release
        cyc(1, 1);
        for (int j = 0; j < 20; j++) begin
            cyc(1, 0);
            check("held_data", ifc.data, 0);
            check("held_busy", ifc.busy, 0);
        end
        cyc(0, 0);
        cyc(1, 0);
        check("held_press", ifc.busy, 1);

        // random activity
        for (int s = 0; s < 150; s++) begin
            lvl = $urandom_range(0, 1);
            len = $urandom_range(1, 24);
            rr  = ($urandom_range(0, 40) == 0);
            for (int j = 0; j < len; j++) begin
                cyc(bit'(lvl), rr && (j == 0));
            end
        end
        repeat (30) cyc(0, 0);

        @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
